// File: rtl/z2_cycle_initiator.sv
// Zorro II style bus-cycle initiator.
// Turns a valid/ready request into one AS_n/UDS_n/LDS_n bus cycle with a
// timeout and a recover phase. Every bus-facing output comes straight from a
// flop, so none of them can glitch.
module z2_cycle_initiator #(
    parameter int SETUP_CYCLES   = 1,   // 1..7 cycles of ADDR/RW before AS_n falls
    parameter int TIMEOUT_CYCLES = 255  // 8..255 WAIT cycles before abort
) (
    input  logic        MEMCLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_be,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [22:0] ADDR,
    output logic        RW,
    output logic        AS_n,
    output logic        UDS_n,
    output logic        LDS_n,
    output logic [15:0] DOUT,
    output logic        DOE,
    input  logic [15:0] DIN,
    input  logic        DTACK_n,
    input  logic        BERR_n
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_ASSERT, S_WAIT, S_LATCH, S_ENDC, S_RECOVER
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_BUS    = 2'b01;
    localparam logic [1:0] ERR_TO     = 2'b10;

    state_t      r_state, w_next;
    logic        r_dtack_s1, r_dtack_s2, r_berr_s1, r_berr_s2;
    logic        r_armed;
    logic        r_rw_h;
    logic [1:0]  r_be_h;
    logic [15:0] r_wdata_h;
    logic [1:0]  r_err_h, w_err_nx;
    logic [7:0]  r_cnt;
    logic        r_as_n, r_uds_n, r_lds_n, r_doe, r_rw_o, r_rsp_valid;
    logic [15:0] r_dout, r_rdata;
    logic [22:0] r_addr;
    logic [1:0]  r_rsp_err;
    logic        w_bus_idle, w_accept, w_be_zero, w_act;

    // Slave is quiet once both synchronised handshakes are released.
    assign w_bus_idle = r_dtack_s2 & r_berr_s2;
    // r_armed keeps ready low through reset and the first edge after it.
    assign req_ready  = r_armed & (r_state == S_IDLE) & w_bus_idle;
    assign w_accept   = req_valid & req_ready;
    assign w_be_zero  = w_accept & (req_be == 2'b00);
    assign w_act      = (w_next == S_ASSERT) | (w_next == S_WAIT) | (w_next == S_LATCH);

    // Two-flop synchronisers for the asynchronous slave handshakes.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            r_dtack_s1 <= 1'b1; r_dtack_s2 <= 1'b1;
            r_berr_s1  <= 1'b1; r_berr_s2  <= 1'b1;
            r_armed    <= 1'b0;
        end else begin
            r_dtack_s1 <= DTACK_n; r_dtack_s2 <= r_dtack_s1;
            r_berr_s1  <= BERR_n;  r_berr_s2  <= r_berr_s1;
            r_armed    <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and error code; BERR wins over DTACK when both are seen.
    always_comb begin
        w_next   = r_state;
        w_err_nx = r_err_h;
        case (r_state)
            S_IDLE:    if (w_accept && req_be != 2'b00) w_next = S_SETUP;
            S_SETUP:   if (r_cnt == SETUP_LAST) w_next = S_ASSERT;
            S_ASSERT:  w_next = S_WAIT;
            S_WAIT: begin
                if (!r_berr_s2) begin
                    w_next   = S_ENDC;
                    w_err_nx = ERR_BUS;
                end else if (!r_dtack_s2) begin
                    w_next   = S_LATCH;
                end else if (r_cnt == TO_LAST) begin
                    w_next   = S_ENDC;
                    w_err_nx = ERR_TO;
                end
            end
            S_LATCH:   w_next = S_ENDC;
            S_ENDC:    w_next = S_RECOVER;
            S_RECOVER: if (w_bus_idle) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Holding registers, error code and the shared setup/timeout counter.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            r_rw_h    <= 1'b1;
            r_be_h    <= 2'b00;
            r_wdata_h <= 16'h0;
            r_err_h   <= ERR_OK;
            r_cnt     <= 8'h0;
        end else begin
            if (w_accept) begin
                r_rw_h    <= req_rw;
                r_be_h    <= req_be;
                r_wdata_h <= req_wdata;
                r_err_h   <= ERR_OK;
            end else begin
                r_err_h   <= w_err_nx;
            end
            if (r_state != w_next)
                r_cnt <= 8'h0;
            else if (r_state == S_SETUP || r_state == S_WAIT)
                r_cnt <= r_cnt + 8'h1;
        end
    end

    // Bus outputs registered from the next state so they line up with it.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            r_as_n  <= 1'b1;
            r_uds_n <= 1'b1;
            r_lds_n <= 1'b1;
            r_doe   <= 1'b0;
            r_dout  <= 16'h0;
            r_rw_o  <= 1'b1;
            r_addr  <= 23'h0;
        end else begin
            r_as_n  <= ~w_act;
            // Read strobes go with AS_n; write strobes wait one cycle for data.
            r_uds_n <= ~(w_act & r_be_h[1] & (r_rw_h | (w_next != S_ASSERT)));
            r_lds_n <= ~(w_act & r_be_h[0] & (r_rw_h | (w_next != S_ASSERT)));
            r_doe   <= ~r_rw_h & (w_act | (w_next == S_ENDC));
            if (w_next == S_ASSERT && !r_rw_h) r_dout <= r_wdata_h;
            if (w_next == S_IDLE || w_next == S_RECOVER) r_rw_o <= 1'b1;
            else if (w_accept)                           r_rw_o <= req_rw;
            if (w_accept && req_be != 2'b00) r_addr <= req_addr;
        end
    end

    // Response pulse; read data only changes on a completed read or empty request.
    always_ff @(posedge MEMCLK or posedge RESET) begin
        if (RESET) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= ERR_OK;
            r_rdata     <= 16'h0;
        end else begin
            r_rsp_valid <= (w_next == S_ENDC) | w_be_zero;
            if (w_next == S_ENDC) r_rsp_err <= w_err_nx;
            else if (w_be_zero)   r_rsp_err <= ERR_OK;
            if (w_be_zero)
                r_rdata <= 16'h0;
            else if (r_state == S_LATCH && r_rw_h)
                r_rdata <= DIN & {{8{r_be_h[1]}}, {8{r_be_h[0]}}};
        end
    end

    assign AS_n      = r_as_n;
    assign UDS_n     = r_uds_n;
    assign LDS_n     = r_lds_n;
    assign DOE       = r_doe;
    assign DOUT      = r_dout;
    assign RW        = r_rw_o;
    assign ADDR      = r_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_z2_cycle_initiator.sv
// Directed bench for z2_cycle_initiator: read, write, bus error, timeout,
// slow DTACK release with an empty request, and reset in mid-cycle.
module tb_z2_cycle_initiator;

    logic        MEMCLK = 1'b0;
    logic        RESET  = 1'b1;
    logic        req_valid = 1'b0, req_rw = 1'b1;
    logic [22:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be    = '0;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [22:0] ADDR;
    logic        RW, AS_n, UDS_n, LDS_n, DOE;
    logic [15:0] DOUT;
    logic [15:0] DIN = '0;
    logic        DTACK_n = 1'b1, BERR_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 MEMCLK = ~MEMCLK;

    z2_cycle_initiator #(.SETUP_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
        .MEMCLK(MEMCLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ADDR(ADDR), .RW(RW), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .DOUT(DOUT), .DOE(DOE), .DIN(DIN), .DTACK_n(DTACK_n), .BERR_n(BERR_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Present a request and hold it until accepted on a rising edge.
    task automatic send(input logic rw, input logic [22:0] a, input logic [15:0] wd,
                        input logic [1:0] be);
        int n = 0;
        @(negedge MEMCLK);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd; req_be = be;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge MEMCLK);
            n++;
        end
        chk("send_ready", req_ready, 1);
        @(posedge MEMCLK);
        #1 req_valid = 1'b0;
    endtask

    // Returns on the negedge of the ASSERT cycle.
    task automatic wait_as();
        int n = 0;
        do begin
            @(negedge MEMCLK);
            n++;
        end while (AS_n !== 1'b0 && n < 50);
        chk("as_seen", AS_n, 0);
    endtask

    // Returns on the negedge where rsp_valid is high; n = negedges waited.
    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge MEMCLK);
            n++;
        end while (rsp_valid !== 1'b1 && n < 60);
        chk("rsp_seen", rsp_valid, 1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge MEMCLK);
        chk("rst_as", AS_n, 1);   chk("rst_uds", UDS_n, 1); chk("rst_lds", LDS_n, 1);
        chk("rst_rw", RW, 1);     chk("rst_doe", DOE, 0);   chk("rst_dout", DOUT, 0);
        chk("rst_addr", ADDR, 0); chk("rst_rdy", req_ready, 0);
        chk("rst_vld", rsp_valid, 0); chk("rst_err", rsp_err, 0); chk("rst_data", rsp_rdata, 0);
        RESET = 1'b0;
        #1 chk("rst_rdy_rel", req_ready, 0);

        // Read, both bytes, DTACK 3 cycles after AS_n
        send(1'b1, 23'h080000, 16'h0, 2'b11);
        wait_as();
        chk("rd_uds", UDS_n, 0); chk("rd_lds", LDS_n, 0);
        chk("rd_rw", RW, 1);     chk("rd_addr", ADDR, 23'h080000); chk("rd_doe", DOE, 0);
        repeat (3) @(negedge MEMCLK);
        DTACK_n = 1'b0; DIN = 16'hA5C3;
        wait_rsp(n);
        chk("rd_data", rsp_rdata, 16'hA5C3); chk("rd_err", rsp_err, 0);
        chk("rd_as_rel", AS_n, 1);           chk("rd_addr_endc", ADDR, 23'h080000);
        DTACK_n = 1'b1;
        @(negedge MEMCLK);
        chk("rd_pulse", rsp_valid, 0); chk("rd_hold", rsp_rdata, 16'hA5C3); chk("rd_rw_rec", RW, 1);

        // Write, lower byte only
        send(1'b0, 23'h000123, 16'h1234, 2'b01);
        wait_as();
        chk("wr_doe", DOE, 1); chk("wr_dout", DOUT, 16'h1234);
        chk("wr_lds_asrt", LDS_n, 1); chk("wr_uds_asrt", UDS_n, 1); chk("wr_rw", RW, 0);
        @(negedge MEMCLK);
        chk("wr_lds", LDS_n, 0); chk("wr_uds", UDS_n, 1);
        DTACK_n = 1'b0;
        wait_rsp(n);
        chk("wr_err", rsp_err, 0); chk("wr_doe_endc", DOE, 1); chk("wr_dout_endc", DOUT, 16'h1234);
        chk("wr_lds_endc", LDS_n, 1);
        DTACK_n = 1'b1;
        @(negedge MEMCLK);
        chk("wr_doe_rec", DOE, 0);

        // BERR and DTACK together
        send(1'b1, 23'h000200, 16'h0, 2'b11);
        wait_as();
        BERR_n = 1'b0; DTACK_n = 1'b0; DIN = 16'hFFFF;
        wait_rsp(n);
        chk("be_err", rsp_err, 2'b01); chk("be_data", rsp_rdata, 16'hA5C3);
        BERR_n = 1'b1; DTACK_n = 1'b1;

        // Timeout: 16 WAIT cycles, ENDC on the 17th negedge after ASSERT
        send(1'b1, 23'h7FFFFF, 16'h0, 2'b10);
        wait_as();
        wait_rsp(n);
        chk("to_cycles", n, 17); chk("to_err", rsp_err, 2'b10); chk("to_as", AS_n, 1);
        @(negedge MEMCLK);
        chk("to_uds", UDS_n, 1);

        // Upper byte read, then slave holds DTACK 5 cycles past AS_n rising
        send(1'b1, 23'h000010, 16'h0, 2'b10);
        wait_as();
        DTACK_n = 1'b0; DIN = 16'h5A5A;
        wait_rsp(n);
        chk("hi_data", rsp_rdata, 16'h5A00); chk("hi_err", rsp_err, 0);
        req_valid = 1'b1; req_rw = 1'b1; req_be = 2'b00; req_addr = 23'h000777;
        for (int i = 0; i < 5; i++) begin
            @(negedge MEMCLK);
            chk("hold_rdy", req_ready, 0);
        end
        DTACK_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge MEMCLK);
            chk("hold_rdy_sync", req_ready, 0);
        end
        @(negedge MEMCLK);
        chk("hold_rdy_up", req_ready, 1);
        // Empty byte-enable request completes with no bus cycle
        @(negedge MEMCLK);
        req_valid = 1'b0;
        chk("be0_vld", rsp_valid, 1); chk("be0_data", rsp_rdata, 0);
        chk("be0_err", rsp_err, 0);   chk("be0_as", AS_n, 1); chk("be0_addr", ADDR, 23'h000010);
        @(negedge MEMCLK);
        chk("be0_pulse", rsp_valid, 0); chk("be0_rdy", req_ready, 1);

        // Reset during WAIT of a write
        send(1'b0, 23'h000321, 16'hBEEF, 2'b11);
        wait_as();
        @(negedge MEMCLK);
        chk("mr_lds", LDS_n, 0);
        #2 RESET = 1'b1;
        #1;
        chk("mr_as", AS_n, 1); chk("mr_uds", UDS_n, 1); chk("mr_lds_rel", LDS_n, 1);
        chk("mr_doe", DOE, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge MEMCLK);
            chk("mr_vld", rsp_valid, 0); chk("mr_rdy", req_ready, 0);
        end
        RESET = 1'b0;
        #1 chk("mr_rdy_rel", req_ready, 0);
        @(negedge MEMCLK);
        chk("mr_rdy_up", req_ready, 1);
        send(1'b1, 23'h000040, 16'h0, 2'b11);
        wait_as();
        DTACK_n = 1'b0; DIN = 16'hC0DE;
        wait_rsp(n);
        chk("post_data", rsp_rdata, 16'hC0DE); chk("post_err", rsp_err, 0);
        DTACK_n = 1'b1;
        repeat (4) @(negedge MEMCLK);
        chk("post_idle_rdy", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait loop is never satisfied.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/z2_cycle_initiator.md
Z2_CYCLE_INITIATOR -- requirements
Module: z2_cycle_initiator

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1, MEMCLK cycles ADDR/RW are driven before AS_n falls (range 1..7).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, MEMCLK cycles in WAIT before timeout abort (8-bit counter, range 8..255).
REQ-003 MEMCLK  input  1  sole clock; all logic rising-edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present; req_ready  output  1  accept, transfer when both high.
REQ-006 req_rw  input  1  1=read, 0=write; req_addr  input  23  word address [23:1]; req_wdata  input  16; req_be  input  2  [1]=upper byte, [0]=lower byte.
REQ-007 rsp_valid  output  1  one-cycle pulse; rsp_rdata  output  16; rsp_err  output  2  00 ok, 01 bus error, 10 timeout.
REQ-008 ADDR  output  23; RW  output  1; AS_n, UDS_n, LDS_n  output  1 each; DOUT  output  16; DOE  output  1  data-bus drive enable.
REQ-009 DIN  input  16; DTACK_n  input  1; BERR_n  input  1 (both asynchronous).

Function
REQ-010 DTACK_n and BERR_n SHALL each pass a 2-flop synchroniser (reset to 1) before use; DIN SHALL be sampled unsynchronised only in LATCH.
REQ-011 States: IDLE, SETUP, ASSERT, WAIT, LATCH, ENDC, RECOVER; encoded in a 3-bit register.
REQ-012 IDLE: req_ready=1 only if synchronised DTACK_n=1 and BERR_n=1; on transfer, capture addr/rw/wdata/be into holding registers, drive ADDR and RW, go SETUP.
REQ-013 req_be=00 SHALL be accepted and complete immediately as rsp_valid with rsp_err=00, rsp_rdata=0, no bus activity, returning to IDLE next cycle.
REQ-014 SETUP: count SETUP_CYCLES cycles, then ASSERT; AS_n, UDS_n, LDS_n remain 1.
REQ-015 ASSERT (one cycle): AS_n=0; read: UDS_n=~be[1], LDS_n=~be[0] in the same cycle; write: DOE=1, DOUT=wdata, strobes stay 1; go WAIT.
REQ-016 WAIT: write strobes assert on the first WAIT cycle; timeout counter clears on entry and increments each cycle.
REQ-017 WAIT exit priority: BERR sync low -> ENDC with err 01; else DTACK sync low -> LATCH; else counter==TIMEOUT_CYCLES-1 -> ENDC with err 10.
REQ-018 BERR and DTACK asserted in the same sampled cycle SHALL report err 01 and not capture data.
REQ-019 LATCH (one cycle): read captures DIN into rsp_rdata (byte lanes with be bit 0 forced to 0); write captures nothing; err 00; go ENDC.
REQ-020 ENDC (one cycle): AS_n, UDS_n, LDS_n=1; rsp_valid=1 with final rsp_err; DOE remains 1 for writes; go RECOVER.
REQ-021 RECOVER: DOE=0; stay until synchronised DTACK_n=1 and BERR_n=1, then IDLE; no new request accepted before IDLE.
REQ-022 ADDR, RW SHALL remain stable from SETUP through ENDC; RW SHALL be 1 in IDLE and RECOVER.
REQ-023 Minimum back-to-back read cycle with DTACK already low at ASSERT: 1 IDLE+SETUP_CYCLES+1+2 sync+1+1+RECOVER cycles; no output may glitch (all bus outputs registered).
REQ-024 rsp_rdata SHALL hold its value until the next rsp_valid.

Reset
REQ-025 While RESET=1: state IDLE, AS_n=UDS_n=LDS_n=1, RW=1, DOE=0, DOUT=0, ADDR=0, req_ready=0, rsp_valid=0, rsp_err=00, rsp_rdata=0, counters 0, synchronisers 1.
REQ-026 Reset asserted mid-cycle SHALL release the bus asynchronously within the same clock edge-independent path and SHALL NOT emit rsp_valid; req_ready first rises the cycle after RESET falls.

Verification
REQ-027 Read: addr 0x100000>>1, be=11, DTACK low 3 cycles after AS_n low, DIN=0xA5C3 -> rsp_rdata=0xA5C3, err 00, UDS_n/LDS_n fall with AS_n.
REQ-028 Write: be=01, wdata=0x1234 -> DOE rises at AS_n fall, LDS_n falls one cycle later, UDS_n stays 1, DOUT=0x1234 held through ENDC, err 00.
REQ-029 Timeout: DTACK_n never asserted, TIMEOUT_CYCLES=16 -> rsp_valid with err 10 exactly 16 WAIT cycles after entry, bus released.
REQ-030 BERR_n and DTACK_n fall together -> err 01, rsp_rdata unchanged from previous response.
REQ-031 Slave holds DTACK_n low 5 cycles after AS_n rises; req_valid held high -> req_ready stays 0 until 2 cycles after DTACK_n rises.
REQ-032 RESET pulsed during WAIT of a write -> AS_n, strobes 1 and DOE 0 immediately, no rsp_valid, next request completes normally.
